// File: rtl/spi_mem_master_if.sv
// Requester-side handshake bundle for spi_mem_master: start/done request channel and read data.
interface spi_mem_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_mem_master.sv
// SPI mode-0 master issuing one 16-bit {addr, rw, data} frame per request to the SPI memory slave.
module spi_mem_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_mem_master_if.slave   req,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned DivW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WaitMax = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int unsigned WaitW   = (WaitMax > 2) ? $clog2(WaitMax) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e           state_q;
    logic [DivW-1:0]  div_cnt_q;
    logic [WaitW-1:0] wait_cnt_q;
    logic [4:0]       tog_cnt_q;
    logic [14:0]      frame_q;   // frame bits still to be sent after the MSB
    logic             rw_q;
    logic [7:0]       rd_shift_q;
    logic [7:0]       rdata_q;
    logic             busy_q;
    logic             done_q;
    logic             sclk_q;
    logic             cs_q;
    logic             mosi_q;

    assign req.busy  = busy_q;
    assign req.done  = done_q;
    assign req.rdata = rdata_q;
    assign sclk      = sclk_q;
    assign cs        = cs_q;
    assign mosi      = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            wait_cnt_q <= '0;
            tog_cnt_q  <= '0;
            frame_q    <= '0;
            rw_q       <= 1'b0;
            rd_shift_q <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req.start) begin
                        frame_q    <= {req.addr[5:0], req.rw, req.wdata};
                        rw_q       <= req.rw;
                        mosi_q     <= req.addr[6];
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (wait_cnt_q == WaitW'(CS_SETUP - 1)) begin
                        wait_cnt_q <= '0;
                        div_cnt_q  <= '0;
                        tog_cnt_q  <= '0;
                        state_q    <= StShift;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (div_cnt_q == DivW'(CLK_DIV - 1)) begin
                        div_cnt_q <= '0;
                        tog_cnt_q <= tog_cnt_q + 1'b1;
                        if (!tog_cnt_q[0]) begin
                            sclk_q <= 1'b1;
                            // Rising toggles 16..31 are the data bits 8..15 of the frame.
                            if (rw_q && tog_cnt_q[4]) begin
                                rd_shift_q <= {rd_shift_q[6:0], miso};
                            end
                        end else begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= frame_q[14];
                            frame_q <= {frame_q[13:0], 1'b0};
                            if (tog_cnt_q == 5'd31) begin
                                mosi_q  <= 1'b0;
                                state_q <= StHold;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (div_cnt_q == DivW'(CLK_DIV - 1)) begin
                        div_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                        cs_q       <= 1'b1;
                        done_q     <= 1'b1;
                        if (rw_q) begin
                            rdata_q <= rd_shift_q;
                        end
                        state_q <= StGap;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (wait_cnt_q == WaitW'(CS_IDLE - 1)) begin
                        wait_cnt_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Scoreboard bench for spi_mem_master: two parameterisations behind a memory-slave model.
module tb_spi_mem_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       start;
    logic       rw_i;
    logic [6:0] addr_i;
    logic [7:0] wdata_i;
    logic       miso;
    logic       sclk0, cs0, mosi0, sclk1, cs1, mosi1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_mem_master_if bus0 ();
    spi_mem_master_if bus1 ();

    assign bus0.start = start && !sel;
    assign bus1.start = start && sel;
    assign bus0.rw    = rw_i;
    assign bus1.rw    = rw_i;
    assign bus0.addr  = addr_i;
    assign bus1.addr  = addr_i;
    assign bus0.wdata = wdata_i;
    assign bus1.wdata = wdata_i;

    spi_mem_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_IDLE(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus0.slave),
        .sclk  (sclk0),
        .cs    (cs0),
        .mosi  (mosi0),
        .miso  (miso)
    );

    spi_mem_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_IDLE(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus1.slave),
        .sclk  (sclk1),
        .cs    (cs1),
        .mosi  (mosi1),
        .miso  (miso)
    );

    wire       sclk_m  = sel ? sclk1 : sclk0;
    wire       cs_m    = sel ? cs1 : cs0;
    wire       mosi_m  = sel ? mosi1 : mosi0;
    wire       busy_m  = sel ? bus1.busy : bus0.busy;
    wire       done_m  = sel ? bus1.done : bus0.done;
    wire [7:0] rdata_m = sel ? bus1.rdata : bus0.rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory slave model: captures mosi on rising sclk, drives miso on falling sclk.
    logic [7:0]  mem [128];
    logic [15:0] cap;
    logic [15:0] s_frame;
    int          bitn;
    int          s_bits;
    logic        s_rw;
    logic [6:0]  s_addr;

    always @(negedge cs_m) begin
        bitn = 0;
        cap  = '0;
    end

    always @(posedge sclk_m) begin
        if (!cs_m) begin
            cap  = {cap[14:0], mosi_m};
            bitn = bitn + 1;
        end
    end

    always @(negedge sclk_m) begin
        if (!cs_m) begin
            if (bitn == 8) begin
                s_rw   = cap[0];
                s_addr = cap[7:1];
            end
            if (bitn >= 8 && bitn <= 15 && s_rw) miso = mem[s_addr][15-bitn];
        end
    end

    always @(posedge cs_m) begin
        miso    = 1'b0;
        s_frame = cap;
        s_bits  = bitn;
        if (bitn == 16 && !cap[8]) mem[cap[15:9]] = cap[7:0];
    end

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          cs_low;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] last_rd [2];

    task automatic push_exp(input logic r, input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        e.frame  = {a, r, d};
        e.rdata  = r ? mem[a] : last_rd[sel];
        e.cs_low = sel ? 67 : 134;
        if (r) last_rd[sel] = mem[a];
        sb.push_back(e);
    endtask

    // Monitor sampled on the falling clk edge, away from DUT updates.
    int         cs_cnt, per_cnt, last_per;
    logic       cs_prev = 1'b1, sclk_prev = 1'b0, done_prev = 1'b0, rise_seen = 1'b0;
    logic [7:0] rd0_prev = '0, rd1_prev = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!cs_m) begin
            if (cs_prev) begin
                cs_cnt    = 1;
                rise_seen = 1'b0;
            end else begin
                cs_cnt++;
            end
        end
        per_cnt++;
        if (sclk_m && !sclk_prev) begin
            if (rise_seen) last_per = per_cnt;
            per_cnt   = 0;
            rise_seen = 1'b1;
        end
        if (done_prev) check_eq("done_pulse", done_m, 1'b0);
        if (done_m && rst_n) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("rdata", rdata_m, e.rdata);
                check_eq("mosi_frame", s_frame, e.frame);
                check_eq("frame_bits", s_bits, 16);
                check_eq("cs_low", cs_cnt, e.cs_low);
                check_eq("sclk_period", last_per, sel ? 4 : 8);
            end
        end
        if (rst_n && bus0.rdata != rd0_prev) check_eq("rdata0_on_done", bus0.done, 1'b1);
        if (rst_n && bus1.rdata != rd1_prev) check_eq("rdata1_on_done", bus1.done, 1'b1);
        rd0_prev  = bus0.rdata;
        rd1_prev  = bus1.rdata;
        cs_prev   = cs_m;
        sclk_prev = sclk_m;
        done_prev = done_m;
    end

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        rw_i    = r;
        addr_i  = a;
        wdata_i = d;
        start   = 1'b1;
        push_exp(r, a, d);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_m && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_m) check_eq("idle_timeout", busy_m, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
        mem[7'h7F] = 8'h3C;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        miso    = 1'b0;
        sel     = 1'b0;
        start   = 1'b0;
        rw_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cs", cs_m, 1'b1);
        check_eq("rst_sclk", sclk_m, 1'b0);
        check_eq("rst_mosi", mosi_m, 1'b0);
        check_eq("rst_busy", busy_m, 1'b0);
        check_eq("rst_done", done_m, 1'b0);
        check_eq("rst_rdata", rdata_m, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, read of preloaded data, read-back of the written byte.
        issue(1'b0, 7'h15, 8'hA5);
        wait_idle();
        issue(1'b1, 7'h7F, 8'h00);
        wait_idle();
        issue(1'b1, 7'h15, 8'hFF);
        wait_idle();

        // start held high through a frame, then accepted again on the first idle cycle.
        @(negedge clk);
        rw_i    = 1'b0;
        addr_i  = 7'h33;
        wdata_i = 8'h5A;
        start   = 1'b1;
        push_exp(1'b0, 7'h33, 8'h5A);
        @(negedge clk);
        rw_i = 1'b1;
        n    = 0;
        while (busy_m && n < 300) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_len", n, 138);
        push_exp(1'b1, 7'h33, 8'h5A);
        @(negedge clk);
        check_eq("restart_cs", cs_m, 1'b0);
        check_eq("restart_busy", busy_m, 1'b1);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset 40 cycles into a read.
        issue(1'b1, 7'h7F, 8'h00);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_cs", cs_m, 1'b1);
        check_eq("abort_sclk", sclk_m, 1'b0);
        check_eq("abort_mosi", mosi_m, 1'b0);
        check_eq("abort_busy", busy_m, 1'b0);
        check_eq("abort_rdata", rdata_m, 8'h00);
        sb.delete();
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b0, 7'h0A, 8'hC3);
        wait_idle();

        // Fast configuration: back-to-back read then write, then read-back.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b1, 7'h15, 8'h00);
        wait_idle();
        issue(1'b0, 7'h40, 8'h99);
        wait_idle();
        issue(1'b1, 7'h40, 8'h00);
        wait_idle();

        repeat (10) @(negedge clk);
        check_eq("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
